jump_physics: RTL and testbench



---
 rtl/jump_physics.sv | 171 +++++++++++++++++
 tb/tb_jump_physics.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/jump_physics.sv
// jump_physics: turns a button hold into a charged jump.
// Charge accumulates while the button is held; on release the man flies a
// discrete parabola (x advances linearly, y follows a decreasing velocity)
// and jump-done is raised for the game state machine once he lands.

module jump_physics #(
  parameter logic [31:0] X_START    = 32'd0,
  parameter int unsigned CHARGE_DIV = 250000,
  parameter int unsigned MAX_CHARGE = 100,
  parameter int unsigned STEP_DIV   = 50000,
  parameter logic [31:0] X_STEP     = 32'd2,
  parameter int unsigned Y_SHIFT    = 4
) (
  input  logic        clk_machine,
  input  logic        rst_machine,
  input  logic        i_btn,
  input  logic        i_reload,
  output logic [31:0] o_x_man,
  output logic [31:0] o_y_man,
  output logic [7:0]  o_charge,
  output logic        o_jump_done,
  output logic        o_busy
);

  localparam logic [31:0] CHARGE_LAST = CHARGE_DIV - 1;
  localparam logic [31:0] STEP_LAST   = STEP_DIV - 1;
  localparam logic [7:0]  CHARGE_MAX  = MAX_CHARGE[7:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FLY    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               btn_q, btn_d;
  logic [31:0]        presc_q, presc_d;
  logic [7:0]         charge_q, charge_d;
  logic [7:0]         steps_q, steps_d;
  logic [31:0]        x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] vy_q, vy_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               rise;
  logic               fall;
  logic [7:0]         charge_inc;

  // Next-state logic: button edge detection, charge accumulation, flight
  // stepping, with reload overriding everything except the held charge.
  always_comb begin
    rise       = i_btn & ~btn_q;
    fall       = ~i_btn & btn_q;
    charge_inc = (charge_q == CHARGE_MAX) ? charge_q : charge_q + 8'd1;

    state_d  = state_q;
    btn_d    = i_btn;
    presc_d  = presc_q;
    charge_d = charge_q;
    steps_d  = steps_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (rise) begin
          state_d  = CHARGE;
          charge_d = '0;
        end
      end

      CHARGE: begin
        if (presc_q == CHARGE_LAST) begin
          presc_d  = '0;
          charge_d = charge_inc;
        end else begin
          presc_d = presc_q + 32'd1;
        end
        // A release in the same cycle as a charge tick sees the new charge.
        if (fall) begin
          presc_d = '0;
          if (charge_d == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d = FLY;
            vy_d    = {24'd0, charge_d} - 32'sd1;
            steps_d = charge_d;
          end
        end
      end

      FLY: begin
        if (presc_q == STEP_LAST) begin
          presc_d = '0;
          x_d     = x_q + X_STEP;
          y_d     = y_q + vy_q;
          vy_d    = vy_q - 32'sd2;
          steps_d = steps_q - 8'd1;
          if (steps_q == 8'd1) begin
            state_d = DONE;
          end
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end

      DONE: begin
        presc_d = '0;
        if (rise) begin
          state_d  = CHARGE;
          charge_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase

    if (i_reload) begin
      state_d  = IDLE;
      presc_d  = '0;
      charge_d = charge_q;
      x_d      = X_START;
      y_d      = '0;
      vy_d     = '0;
    end

    done_d = (state_d == DONE);
    busy_d = (state_d == CHARGE) || (state_d == FLY);
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      state_q  <= IDLE;
      btn_q    <= 1'b0;
      presc_q  <= '0;
      charge_q <= '0;
      steps_q  <= '0;
      x_q      <= X_START;
      y_q      <= '0;
      vy_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_d;
      presc_q  <= presc_d;
      charge_q <= charge_d;
      steps_q  <= steps_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign o_x_man     = x_q;
  assign o_y_man     = y_q >>> Y_SHIFT;
  assign o_charge    = charge_q;
  assign o_jump_done = done_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_jump_physics.sv
// Directed testbench for jump_physics with small dividers so that charge
// and flight timing can be followed cycle by cycle.

module tb_jump_physics;

  logic        clk_machine;
  logic        rst_machine;
  logic        i_btn;
  logic        i_reload;
  logic [31:0] o_x_man;
  logic [31:0] o_y_man;
  logic [7:0]  o_charge;
  logic        o_jump_done;
  logic        o_busy;

  int checks;
  int errors;

  jump_physics #(
    .X_START   (32'd0),
    .CHARGE_DIV(4),
    .MAX_CHARGE(5),
    .STEP_DIV  (2),
    .X_STEP    (32'd10),
    .Y_SHIFT   (0)
  ) dut (
    .clk_machine(clk_machine),
    .rst_machine(rst_machine),
    .i_btn      (i_btn),
    .i_reload   (i_reload),
    .o_x_man    (o_x_man),
    .o_y_man    (o_y_man),
    .o_charge   (o_charge),
    .o_jump_done(o_jump_done),
    .o_busy     (o_busy)
  );

  // Free-running 100 MHz-style clock; period is irrelevant to the checks.
  initial clk_machine = 1'b0;
  always #5 clk_machine = ~clk_machine;

  // One active edge, then settle at the falling edge for sampling/driving.
  task automatic tick;
    @(posedge clk_machine);
    @(negedge clk_machine);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset asserted from time zero, released between edges.
  task automatic test_reset;
    rst_machine = 1'b1;
    i_btn       = 1'b0;
    i_reload    = 1'b0;
    tick_n(2);
    #2 rst_machine = 1'b0;
    @(negedge clk_machine);
    checks++; if (o_x_man !== 32'd0) begin errors++; $display("[TB] FAIL reset_x: got %0d expected 0", o_x_man); end
    checks++; if (o_y_man !== 32'd0) begin errors++; $display("[TB] FAIL reset_y: got %0d expected 0", o_y_man); end
    checks++; if (o_charge !== 8'd0) begin errors++; $display("[TB] FAIL reset_charge: got %0d expected 0", o_charge); end
    checks++; if (o_jump_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", o_jump_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
  endtask

  // 12-cycle press: release coincides with the third charge tick -> charge 3.
  task automatic test_normal_jump;
    logic [31:0] exp_y [3];
    exp_y[0] = 32'd2; exp_y[1] = 32'd2; exp_y[2] = 32'd0;
    i_btn = 1'b1;
    tick_n(12);
    checks++; if (o_charge !== 8'd2) begin errors++; $display("[TB] FAIL normal_charge_held: got %0d expected 2", o_charge); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL normal_busy_charge: got %b expected 1", o_busy); end
    i_btn = 1'b0;
    tick();
    checks++; if (o_charge !== 8'd3) begin errors++; $display("[TB] FAIL normal_charge_release: got %0d expected 3", o_charge); end
    checks++; if (o_x_man !== 32'd0) begin errors++; $display("[TB] FAIL normal_x_launch: got %0d expected 0", o_x_man); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_x_man !== 32'(10 * k)) begin errors++; $display("[TB] FAIL normal_x_hold%0d: got %0d expected %0d", k, o_x_man, 10 * k); end
      checks++; if (o_jump_done !== 1'b0) begin errors++; $display("[TB] FAIL normal_done_early%0d: got %b expected 0", k, o_jump_done); end
      tick();
      checks++; if (o_x_man !== 32'(10 * (k + 1))) begin errors++; $display("[TB] FAIL normal_x_step%0d: got %0d expected %0d", k, o_x_man, 10 * (k + 1)); end
      checks++; if (o_y_man !== exp_y[k]) begin errors++; $display("[TB] FAIL normal_y_step%0d: got %0d expected %0d", k, o_y_man, exp_y[k]); end
    end
    checks++; if (o_jump_done !== 1'b1) begin errors++; $display("[TB] FAIL normal_done: got %b expected 1", o_jump_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL normal_busy_done: got %b expected 0", o_busy); end
    tick_n(5);
    checks++; if (o_jump_done !== 1'b1) begin errors++; $display("[TB] FAIL normal_done_held: got %b expected 1", o_jump_done); end
    checks++; if (o_x_man !== 32'd30) begin errors++; $display("[TB] FAIL normal_x_final: got %0d expected 30", o_x_man); end
  endtask

  // Reload from DONE, then a long hold that saturates the charge at 5.
  task automatic test_saturation;
    logic [31:0] exp_y [5];
    exp_y[0] = 32'd4; exp_y[1] = 32'd6; exp_y[2] = 32'd6; exp_y[3] = 32'd4; exp_y[4] = 32'd0;
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
    checks++; if (o_x_man !== 32'd0) begin errors++; $display("[TB] FAIL sat_reload_x: got %0d expected 0", o_x_man); end
    checks++; if (o_jump_done !== 1'b0) begin errors++; $display("[TB] FAIL sat_reload_done: got %b expected 0", o_jump_done); end
    checks++; if (o_charge !== 8'd3) begin errors++; $display("[TB] FAIL sat_reload_charge_kept: got %0d expected 3", o_charge); end
    i_btn = 1'b1;
    tick_n(40);
    checks++; if (o_charge !== 8'd5) begin errors++; $display("[TB] FAIL sat_charge: got %0d expected 5", o_charge); end
    i_btn = 1'b0;
    tick();
    checks++; if (o_charge !== 8'd5) begin errors++; $display("[TB] FAIL sat_charge_release: got %0d expected 5", o_charge); end
    for (int k = 0; k < 5; k++) begin
      tick_n(2);
      checks++; if (o_y_man !== exp_y[k]) begin errors++; $display("[TB] FAIL sat_y_step%0d: got %0d expected %0d", k, o_y_man, exp_y[k]); end
    end
    checks++; if (o_x_man !== 32'd50) begin errors++; $display("[TB] FAIL sat_x_final: got %0d expected 50", o_x_man); end
    checks++; if (o_jump_done !== 1'b1) begin errors++; $display("[TB] FAIL sat_done: got %b expected 1", o_jump_done); end
  endtask

  // Short tap from DONE: charge stays 0, DONE re-entered, x unchanged.
  task automatic test_tap;
    i_btn = 1'b1;
    tick();
    checks++; if (o_jump_done !== 1'b0) begin errors++; $display("[TB] FAIL tap_done_drop: got %b expected 0", o_jump_done); end
    checks++; if (o_charge !== 8'd0) begin errors++; $display("[TB] FAIL tap_charge_clear: got %0d expected 0", o_charge); end
    tick();
    i_btn = 1'b0;
    tick();
    checks++; if (o_jump_done !== 1'b1) begin errors++; $display("[TB] FAIL tap_done: got %b expected 1", o_jump_done); end
    checks++; if (o_x_man !== 32'd50) begin errors++; $display("[TB] FAIL tap_x: got %0d expected 50", o_x_man); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL tap_busy: got %b expected 0", o_busy); end
  endtask

  // Button toggles ignored in flight; reload with a rise aborts the jump.
  task automatic test_reload;
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
    i_btn = 1'b1;
    tick_n(12);
    i_btn = 1'b0;
    tick_n(3);
    checks++; if (o_x_man !== 32'd10 || o_y_man !== 32'd2) begin errors++; $display("[TB] FAIL reload_step1: got x=%0d y=%0d expected x=10 y=2", o_x_man, o_y_man); end
    i_btn = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b1 || o_x_man !== 32'd10) begin errors++; $display("[TB] FAIL reload_ignore_rise: got busy=%b x=%0d expected busy=1 x=10", o_busy, o_x_man); end
    i_btn = 1'b0;
    tick();
    checks++; if (o_x_man !== 32'd20 || o_y_man !== 32'd2) begin errors++; $display("[TB] FAIL reload_ignore_fall: got x=%0d y=%0d expected x=20 y=2", o_x_man, o_y_man); end
    tick();
    i_reload = 1'b1;
    i_btn    = 1'b1;
    tick();
    i_reload = 1'b0;
    checks++; if (o_x_man !== 32'd0 || o_y_man !== 32'd0) begin errors++; $display("[TB] FAIL reload_pos: got x=%0d y=%0d expected x=0 y=0", o_x_man, o_y_man); end
    checks++; if (o_jump_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reload_flags: got done=%b busy=%b expected done=0 busy=0", o_jump_done, o_busy); end
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reload_idle_held: got busy=%b expected 0", o_busy); end
    i_btn = 1'b0;
    tick();
  endtask

  // Second jump from DONE, then async reset in the middle of charging.
  task automatic test_rejump_async_reset;
    i_btn = 1'b1;
    tick_n(12);
    i_btn = 1'b0;
    tick_n(7);
    checks++; if (o_x_man !== 32'd30 || o_jump_done !== 1'b1) begin errors++; $display("[TB] FAIL rejump_first: got x=%0d done=%b expected x=30 done=1", o_x_man, o_jump_done); end
    i_btn = 1'b1;
    tick();
    checks++; if (o_jump_done !== 1'b0 || o_charge !== 8'd0 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL rejump_start: got done=%b charge=%0d busy=%b expected 0 0 1", o_jump_done, o_charge, o_busy); end
    tick_n(5);
    checks++; if (o_charge !== 8'd1) begin errors++; $display("[TB] FAIL rejump_charge: got %0d expected 1", o_charge); end
    #2 rst_machine = 1'b1;
    #1;
    checks++; if (o_x_man !== 32'd0 || o_y_man !== 32'd0 || o_charge !== 8'd0) begin errors++; $display("[TB] FAIL async_reset_vals: got x=%0d y=%0d charge=%0d expected 0 0 0", o_x_man, o_y_man, o_charge); end
    checks++; if (o_busy !== 1'b0 || o_jump_done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_flags: got busy=%b done=%b expected 0 0", o_busy, o_jump_done); end
    #1 rst_machine = 1'b0;
    @(negedge clk_machine);
    checks++; if (o_busy !== 1'b1 || o_charge !== 8'd0) begin errors++; $display("[TB] FAIL held_through_reset: got busy=%b charge=%0d expected busy=1 charge=0", o_busy, o_charge); end
    i_btn = 1'b0;
    tick();
    checks++; if (o_jump_done !== 1'b1 || o_x_man !== 32'd0) begin errors++; $display("[TB] FAIL post_reset_tap: got done=%b x=%0d expected done=1 x=0", o_jump_done, o_x_man); end
  endtask

  // Scenario sequence; each task leaves the DUT in the state the next expects.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal_jump();
    test_saturation();
    test_tap();
    test_reload();
    test_rejump_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
